// File: rtl/pipe_mux_pkg.sv
// Shared constants for pipe_mux_n: FSM state encodings and the select-width helper.
package pipe_mux_pkg;

    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] FULL  = 2'd1;
    localparam logic [1:0] SKID  = 2'd2;

    // Width needed to encode n selects; never less than one bit.
    function automatic int clog2_sel(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w = w + 1;
        return w;
    endfunction

endpackage

// File: rtl/mux_n_comb.sv
// Pure combinational N:1 word select with out-of-range detection; out-of-range yields a zero word.
module mux_n_comb
    import pipe_mux_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int NUM_IN = 8,
    parameter int SEL_W  = clog2_sel(NUM_IN)
) (
    input  logic [NUM_IN*WIDTH-1:0] d_i,
    input  logic [SEL_W-1:0]        sel_i,
    output logic [WIDTH-1:0]        word_o,
    output logic                    err_o
);

    always_comb begin
        // NOTE: every output gets a default before the loop so no latch is inferred.
        word_o = '0;
        err_o  = (int'(sel_i) >= NUM_IN);
        for (int k = 0; k < NUM_IN; k++) begin
            if (sel_i == SEL_W'(k)) word_o = d_i[k*WIDTH +: WIDTH];
        end
    end

endmodule

// File: rtl/pipe_mux_n.sv
// Registered N:1 mux with valid/ready handshake and a one-entry skid register.
// Optional even-parity output P is built when PIPE_MUX_PARITY_EN is defined.
module pipe_mux_n
    import pipe_mux_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int NUM_IN = 8,
    parameter int SEL_W  = clog2_sel(NUM_IN)
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [NUM_IN*WIDTH-1:0] D,
    input  logic [SEL_W-1:0]        S,
    input  logic                    IN_VALID,
    output logic                    IN_READY,
    output logic [WIDTH-1:0]        Y,
    output logic                    ERR,
`ifdef PIPE_MUX_PARITY_EN
    output logic                    P,
`endif
    output logic                    OUT_VALID,
    input  logic                    OUT_READY
);

    logic [WIDTH-1:0] sel_word;
    logic             sel_err;

    mux_n_comb #(.WIDTH(WIDTH), .NUM_IN(NUM_IN), .SEL_W(SEL_W)) u_mux (
        .d_i   (D),
        .sel_i (S),
        .word_o(sel_word),
        .err_o (sel_err)
    );

    logic [1:0]       state_q, state_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] main_word_q, main_word_d, skid_word_q, skid_word_d;
    logic             main_err_q, main_err_d, skid_err_q, skid_err_d;
`ifdef PIPE_MUX_PARITY_EN
    logic             main_par_q, main_par_d, skid_par_q, skid_par_d;
`endif

    logic accept, drain;
    assign accept = IN_VALID & in_ready_q;
    assign drain  = out_valid_q & OUT_READY;

    always_comb begin
        state_d     = state_q;
        main_word_d = main_word_q;
        main_err_d  = main_err_q;
        skid_word_d = skid_word_q;
        skid_err_d  = skid_err_q;
`ifdef PIPE_MUX_PARITY_EN
        main_par_d  = main_par_q;
        skid_par_d  = skid_par_q;
`endif
        case (state_q)
            EMPTY: begin
                if (accept) begin
                    main_word_d = sel_word;
                    main_err_d  = sel_err;
`ifdef PIPE_MUX_PARITY_EN
                    main_par_d  = ^sel_word;
`endif
                    state_d     = FULL;
                end
            end
            FULL: begin
                if (accept && drain) begin
                    main_word_d = sel_word;
                    main_err_d  = sel_err;
`ifdef PIPE_MUX_PARITY_EN
                    main_par_d  = ^sel_word;
`endif
                end else if (accept) begin
                    skid_word_d = sel_word;
                    skid_err_d  = sel_err;
`ifdef PIPE_MUX_PARITY_EN
                    skid_par_d  = ^sel_word;
`endif
                    state_d     = SKID;
                end else if (drain) begin
                    state_d     = EMPTY;
                end
            end
            SKID: begin
                if (drain) begin
                    main_word_d = skid_word_q;
                    main_err_d  = skid_err_q;
`ifdef PIPE_MUX_PARITY_EN
                    main_par_d  = skid_par_q;
`endif
                    state_d     = FULL;
                end
            end
            default: state_d = EMPTY;
        endcase
        // Handshake flags are registered copies of the next state, so IN_READY never sees OUT_READY combinationally.
        in_ready_d  = (state_d != SKID);
        out_valid_d = (state_d != EMPTY);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            main_word_q <= '0;
            main_err_q  <= 1'b0;
            skid_word_q <= '0;
            skid_err_q  <= 1'b0;
`ifdef PIPE_MUX_PARITY_EN
            main_par_q  <= 1'b0;
            skid_par_q  <= 1'b0;
`endif
        end else begin
            // NOTE: sequential state uses non-blocking assignment so all flops update together.
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            main_word_q <= main_word_d;
            main_err_q  <= main_err_d;
            skid_word_q <= skid_word_d;
            skid_err_q  <= skid_err_d;
`ifdef PIPE_MUX_PARITY_EN
            main_par_q  <= main_par_d;
            skid_par_q  <= skid_par_d;
`endif
        end
    end

    assign IN_READY  = in_ready_q;
    assign OUT_VALID = out_valid_q;
    assign Y         = main_word_q;
    assign ERR       = main_err_q;
`ifdef PIPE_MUX_PARITY_EN
    assign P         = main_par_q;
`endif

endmodule

// File: tb/tb_pipe_mux_n.sv
// Directed self-checking bench for pipe_mux_n (NUM_IN=8 main instance, NUM_IN=6 range instance).
module tb_pipe_mux_n;

    logic         CLK;
    logic         RST;
    logic [127:0] D;
    logic [2:0]   S;
    logic         in_valid8, in_valid6;
    logic         out_ready;

    logic         in_ready8, out_valid8, err8;
    logic [15:0]  y8;
    logic         in_ready6, out_valid6, err6;
    logic [15:0]  y6;
`ifdef PIPE_MUX_PARITY_EN
    logic         p8, p6;
`endif

    int checks = 0;
    int errors = 0;

    pipe_mux_n #(.WIDTH(16), .NUM_IN(8)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .D        (D),
        .S        (S),
        .IN_VALID (in_valid8),
        .IN_READY (in_ready8),
        .Y        (y8),
        .ERR      (err8),
`ifdef PIPE_MUX_PARITY_EN
        .P        (p8),
`endif
        .OUT_VALID(out_valid8),
        .OUT_READY(out_ready)
    );

    pipe_mux_n #(.WIDTH(16), .NUM_IN(6)) dut6 (
        .CLK      (CLK),
        .RST      (RST),
        .D        (D[95:0]),
        .S        (S),
        .IN_VALID (in_valid6),
        .IN_READY (in_ready6),
        .Y        (y6),
        .ERR      (err6),
`ifdef PIPE_MUX_PARITY_EN
        .P        (p6),
`endif
        .OUT_VALID(out_valid6),
        .OUT_READY(out_ready)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the rising edge.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic load_pattern();
        for (int k = 0; k < 8; k++) D[k*16 +: 16] = 16'hA000 + 16'(k);
    endtask

    initial begin
        RST       = 1'b1;
        D         = '0;
        S         = '0;
        in_valid8 = 1'b0;
        in_valid6 = 1'b0;
        out_ready = 1'b0;

        // Reset held with random inputs
        for (int i = 0; i < 4; i++) begin
            D         = {$urandom, $urandom, $urandom, $urandom};
            S         = 3'($urandom_range(0, 7));
            in_valid8 = 1'($urandom_range(0, 1));
            in_valid6 = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            step();
            check("rst_y", 32'(y8), 32'h0);
            check("rst_err", 32'(err8), 32'h0);
            check("rst_out_valid", 32'(out_valid8), 32'h0);
            check("rst_in_ready", 32'(in_ready8), 32'h1);
        end
        in_valid8 = 1'b0;
        in_valid6 = 1'b0;
        out_ready = 1'b1;
        load_pattern();
        RST = 1'b0;
        step();
        check("idle_out_valid", 32'(out_valid8), 32'h0);

        // Single beat S=5
        S = 3'd5;
        in_valid8 = 1'b1;
        step();
        in_valid8 = 1'b0;
        check("single_y", 32'(y8), 32'hA005);
        check("single_err", 32'(err8), 32'h0);
        check("single_out_valid", 32'(out_valid8), 32'h1);
`ifdef PIPE_MUX_PARITY_EN
        check("single_parity", 32'(p8), 32'h0);
`endif
        step();
        check("single_out_valid_drop", 32'(out_valid8), 32'h0);

        // Streaming S=0..7 at full rate
        for (int i = 0; i < 8; i++) begin
            S = 3'(i);
            in_valid8 = 1'b1;
            step();
            check($sformatf("stream_y%0d", i), 32'(y8), 32'hA000 + 32'(i));
            check($sformatf("stream_ov%0d", i), 32'(out_valid8), 32'h1);
            check($sformatf("stream_ir%0d", i), 32'(in_ready8), 32'h1);
        end
        in_valid8 = 1'b0;
        step();
        check("stream_end_out_valid", 32'(out_valid8), 32'h0);

        // Back-pressure fills main then skid
        out_ready = 1'b0;
        S = 3'd1;
        in_valid8 = 1'b1;
        step();
        check("bp_first_y", 32'(y8), 32'hA001);
        check("bp_first_in_ready", 32'(in_ready8), 32'h1);
        S = 3'd2;
        step();
        check("bp_skid_in_ready", 32'(in_ready8), 32'h0);
        check("bp_skid_y", 32'(y8), 32'hA001);
        in_valid8 = 1'b0;
        S = 3'd6;
        step();
        check("bp_hold_y", 32'(y8), 32'hA001);
        check("bp_hold_out_valid", 32'(out_valid8), 32'h1);
        out_ready = 1'b1;
        step();
        check("bp_second_y", 32'(y8), 32'hA002);
        check("bp_second_in_ready", 32'(in_ready8), 32'h1);
        check("bp_second_out_valid", 32'(out_valid8), 32'h1);
        step();
        check("bp_drained", 32'(out_valid8), 32'h0);

        // Range check on NUM_IN=6 instance
        S = 3'd5;
        in_valid6 = 1'b1;
        step();
        check("range_s5_y", 32'(y6), 32'hA005);
        check("range_s5_err", 32'(err6), 32'h0);
        S = 3'd6;
        step();
        check("range_s6_y", 32'(y6), 32'h0);
        check("range_s6_err", 32'(err6), 32'h1);
        S = 3'd7;
        step();
        check("range_s7_y", 32'(y6), 32'h0);
        check("range_s7_err", 32'(err6), 32'h1);
        check("range_s7_out_valid", 32'(out_valid6), 32'h1);
        S = 3'd3;
        step();
        check("range_s3_y", 32'(y6), 32'hA003);
        check("range_s3_err", 32'(err6), 32'h0);
        in_valid6 = 1'b0;
        step();
        check("range_drained", 32'(out_valid6), 32'h0);

        // Mid-operation reset while in SKID
        out_ready = 1'b0;
        S = 3'd4;
        in_valid8 = 1'b1;
        step();
        S = 3'd7;
        step();
        check("mid_in_skid", 32'(in_ready8), 32'h0);
        in_valid8 = 1'b0;
        #2 RST = 1'b1;
        #1;
        check("mid_rst_out_valid", 32'(out_valid8), 32'h0);
        check("mid_rst_in_ready", 32'(in_ready8), 32'h1);
        check("mid_rst_y", 32'(y8), 32'h0);
        #1 RST = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("mid_no_stale%0d", i), 32'(out_valid8), 32'h0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
